// File: rtl/ds_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : ds_addr_seq
// Purpose  : Walks the negedge address register over every kept pixel of a
//            STEP-decimated image, issuing one read handshake per pixel.
// Revision : 1.0
// ============================================================================
module ds_addr_seq #(
  parameter int          IMG_W = 256,
  parameter int          IMG_H = 256,
  parameter int          STEP  = 2,
  parameter logic [31:0] BASE  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        rd_req,
  output logic [2:0]  abus_en,
  output logic [3:0]  cbus_en,
  output logic [31:0] cbus_out,
  output logic        inc_en,
  output logic [31:0] pix_cnt
);

  localparam logic [31:0] c_OUT_W      = 32'(IMG_W / STEP);
  localparam logic [31:0] c_OUT_H      = 32'(IMG_H / STEP);
  localparam logic [31:0] c_ROW_STRIDE = 32'(STEP * IMG_W);
  localparam logic [31:0] c_STEP_LAST  = 32'(STEP - 1);
  localparam logic [3:0]  c_CBUS_LOAD  = 4'b1010;
  localparam logic [2:0]  c_ABUS_DRIVE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_REQ      = 3'd2,
    S_ADV      = 3'd3,
    S_NEXT_ROW = 3'd4,
    S_FIN      = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_row_base;
  logic [31:0] r_row;
  logic [31:0] r_col;
  logic [31:0] r_step;
  logic [31:0] r_pix_cnt;
  logic        w_col_more;
  logic        w_row_more;

  assign w_col_more = (r_col < c_OUT_W - 32'd1);
  assign w_row_more = (r_row < c_OUT_H - 32'd1);
  assign pix_cnt    = r_pix_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row_base <= 32'd0;
      r_row      <= 32'd0;
      r_col      <= 32'd0;
      r_step     <= 32'd0;
      r_pix_cnt  <= 32'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_row_base <= BASE;
            r_row      <= 32'd0;
            r_col      <= 32'd0;
            r_pix_cnt  <= 32'd0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            r_pix_cnt <= r_pix_cnt + 32'd1;
            if (w_col_more) begin
              r_col  <= r_col + 32'd1;
              r_step <= 32'd0;
            end
          end
        end
        S_ADV: r_step <= r_step + 32'd1;
        S_NEXT_ROW: begin
          r_row_base <= r_row_base + c_ROW_STRIDE;
          r_col      <= 32'd0;
          if (w_row_more) r_row <= r_row + 32'd1;
        end
        default: ;
      endcase
    end
  end

  // Moore decode: every output depends only on the current state and counters.
  always_comb begin
    w_next   = r_state;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    rd_req   = 1'b0;
    abus_en  = 3'b000;
    cbus_en  = 4'b0000;
    cbus_out = 32'd0;
    inc_en   = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LOAD;
      S_LOAD: begin
        cbus_en  = c_CBUS_LOAD;
        cbus_out = r_row_base;
        w_next   = S_REQ;
      end
      S_REQ: begin
        rd_req  = 1'b1;
        abus_en = c_ABUS_DRIVE;
        if (mem_ack) w_next = w_col_more ? S_ADV : S_NEXT_ROW;
      end
      S_ADV: begin
        inc_en = 1'b1;
        if (r_step == c_STEP_LAST) w_next = S_REQ;
      end
      S_NEXT_ROW: w_next = w_row_more ? S_LOAD : S_FIN;
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ds_addr_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ds_addr_seq
// Purpose  : Directed bench for ds_addr_seq with a negedge address register
//            model and an expected-address scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ds_addr_seq;

  logic clk;
  logic rst;
  logic start;
  logic mem_ack;
  logic sel;

  logic        a_busy, a_done, a_rd_req, a_inc_en;
  logic [2:0]  a_abus_en;
  logic [3:0]  a_cbus_en;
  logic [31:0] a_cbus_out, a_pix_cnt;
  logic        b_busy, b_done, b_rd_req, b_inc_en;
  logic [2:0]  b_abus_en;
  logic [3:0]  b_cbus_en;
  logic [31:0] b_cbus_out, b_pix_cnt;

  logic        o_busy, o_done, o_rd_req, o_inc_en;
  logic [2:0]  o_abus_en;
  logic [3:0]  o_cbus_en;
  logic [31:0] o_cbus_out, o_pix_cnt;

  logic [31:0] areg;
  logic [31:0] exp_q[$];
  int          total;
  int          bad;
  int          cyc;
  int          ack_delay;
  int          wcnt;
  int          cfg_w, cfg_h, cfg_s;
  logic [31:0] cfg_base;

  ds_addr_seq #(.IMG_W(8), .IMG_H(4), .STEP(2), .BASE(32'h100)) dut_a (
    .clk(clk), .rst(rst), .start(start & ~sel), .mem_ack(mem_ack),
    .busy(a_busy), .done(a_done), .rd_req(a_rd_req), .abus_en(a_abus_en),
    .cbus_en(a_cbus_en), .cbus_out(a_cbus_out), .inc_en(a_inc_en),
    .pix_cnt(a_pix_cnt)
  );

  ds_addr_seq #(.IMG_W(3), .IMG_H(2), .STEP(1), .BASE(32'hFFFF_FFFE)) dut_b (
    .clk(clk), .rst(rst), .start(start & sel), .mem_ack(mem_ack),
    .busy(b_busy), .done(b_done), .rd_req(b_rd_req), .abus_en(b_abus_en),
    .cbus_en(b_cbus_en), .cbus_out(b_cbus_out), .inc_en(b_inc_en),
    .pix_cnt(b_pix_cnt)
  );

  assign o_busy     = sel ? b_busy     : a_busy;
  assign o_done     = sel ? b_done     : a_done;
  assign o_rd_req   = sel ? b_rd_req   : a_rd_req;
  assign o_inc_en   = sel ? b_inc_en   : a_inc_en;
  assign o_abus_en  = sel ? b_abus_en  : a_abus_en;
  assign o_cbus_en  = sel ? b_cbus_en  : a_cbus_en;
  assign o_cbus_out = sel ? b_cbus_out : a_cbus_out;
  assign o_pix_cnt  = sel ? b_pix_cnt  : a_pix_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The address/data register being commanded: it changes on the falling edge.
  always @(negedge clk) begin
    if (o_cbus_en == 4'b1010) areg <= o_cbus_out;
    else if (o_inc_en)        areg <= areg + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_walk();
    logic [31:0] addr;
    for (int r = 0; r < cfg_h / cfg_s; r++) begin
      for (int c = 0; c < cfg_w / cfg_s; c++) begin
        addr = cfg_base + 32'(r * cfg_s * cfg_w) + 32'(c * cfg_s);
        exp_q.push_back(addr);
      end
    end
  endtask

  // One clock: drive mem_ack after the edge, then check the read bus mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!o_rd_req) begin
      wcnt    = 0;
      mem_ack = (ack_delay == 0);
    end else begin
      mem_ack = (wcnt >= ack_delay);
      wcnt++;
    end
    @(negedge clk);
    #1;
    if (o_rd_req) begin
      chk("abus_en_in_req", 64'(o_abus_en), 64'(3'b010));
      chk("no_cmd_in_req", 64'({o_inc_en, o_cbus_en}), 64'd0);
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_read: observed addr=%0h expected none", areg);
      end
      if (exp_q.size() > 0) begin
        chk("read_addr", 64'(areg), 64'(exp_q[0]));
        if (mem_ack) void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic run_walk(input int exp_done, input logic [31:0] exp_pix, input bit poke);
    push_walk();
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    chk("load_in_cycle1", 64'(o_cbus_en), 64'(4'b1010));
    while (o_done !== 1'b1 && cyc < 300) begin
      start = poke && (cyc == 2);
      tick();
    end
    start = 1'b0;
    chk("done_cycle", 64'(cyc), 64'(exp_done));
    chk("pix_cnt_at_done", 64'(o_pix_cnt), 64'(exp_pix));
    chk("busy_in_fin", 64'(o_busy), 64'd1);
    start = poke;
    tick();
    start = 1'b0;
    chk("done_single_pulse", 64'(o_done), 64'd0);
    chk("idle_after_fin", 64'(o_busy), 64'd0);
    chk("all_reads_seen", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; wcnt = 0; ack_delay = 0;
    sel = 1'b0; rst = 1'b1; start = 1'b0; mem_ack = 1'b0;
    cfg_w = 8; cfg_h = 4; cfg_s = 2; cfg_base = 32'h100;
    tick();
    tick();
    chk("reset_ctrl", 64'({o_busy, o_done, o_rd_req, o_abus_en, o_cbus_en, o_inc_en}), 64'd0);
    chk("reset_cbus_out", 64'(o_cbus_out), 64'd0);
    chk("reset_pix_cnt", 64'(o_pix_cnt), 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_before_start", 64'(o_busy), 64'd0);

    run_walk(25, 32'd8, 1'b0);

    ack_delay = 3;
    run_walk(49, 32'd8, 1'b0);
    ack_delay = 0;

    run_walk(25, 32'd8, 1'b1);

    // Abandon the walk in the first ADV of row 1 (cycle 15 with zero-wait acks).
    push_walk();
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
    while (cyc < 15) tick();
    chk("adv_row1_inc", 64'(o_inc_en), 64'd1);
    chk("pix_before_rst", 64'(o_pix_cnt), 64'd5);
    rst = 1'b1;
    tick();
    exp_q.delete();
    chk("rst_mid_ctrl", 64'({o_busy, o_done, o_rd_req, o_abus_en, o_cbus_en, o_inc_en}), 64'd0);
    chk("rst_mid_cbus_out", 64'(o_cbus_out), 64'd0);
    chk("rst_mid_pix_cnt", 64'(o_pix_cnt), 64'd0);
    rst = 1'b0;
    run_walk(25, 32'd8, 1'b0);

    sel = 1'b1;
    cfg_w = 3; cfg_h = 2; cfg_s = 1; cfg_base = 32'hFFFF_FFFE;
    tick();
    run_walk(15, 32'd6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ds_addr_seq.md
# ds_addr_seq

Address-walk controller for the downsampling processor's 32-bit address/data register (the negedge-updated register with a load-from-C-bus path and an increment path). On `start` it walks the register through the source address of every kept pixel of an IMG_W × IMG_H image decimated by STEP in both axes. For each kept pixel it issues one memory read handshake. It raises `done` when the image is finished. It issues only the register's existing commands: load (`cbus_en=4'b1010`), increment (`inc_en`) and drive-onto-A-bus (`abus_en=3'b010`).

## Interface
- IMG_W, 256, source image width in pixels (≥ STEP)
- IMG_H, 256, source image height in rows (≥ STEP)
- STEP, 2, decimation factor (≥ 1); OUT_W = IMG_W/STEP, OUT_H = IMG_H/STEP (floor)
- BASE, 32'h0, address of source pixel (0,0)
- clock  in  1  system clock; controller updates on posedge
- rst  in  1  reset rst, synchronous, active-high
- start  in  1  begin a walk; sampled only in IDLE
- mem_ack  in  1  memory accepted the read; meaningful only while rd_req=1
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of walk
- rd_req  out  1  read request; the address is the register value on the A bus
- abus_en  out  3  3'b010 while rd_req=1, else 3'b000
- cbus_en  out  4  4'b1010 in LOAD, else 4'b0000
- cbus_out  out  32  row base address; value to load
- inc_en  out  1  register increment command
- pix_cnt  out  32  acknowledged reads since last start

## Operation
- States: IDLE, LOAD, REQ, ADV, NEXT_ROW, FIN.
- Outputs are decoded from the current state and counters only (Moore).
- Internal state: row_base (32 bit), row index r, column index c, step counter s.
- IDLE: all outputs 0. On start=1: row_base←BASE, r←0, c←0, pix_cnt←0, go to LOAD. start is ignored in all other states.
- LOAD (1 cycle): cbus_out=row_base, cbus_en=4'b1010. Then go to REQ.
- REQ: rd_req=1, abus_en=3'b010. Stay in REQ until mem_ack=1 is sampled. On the ack edge, pix_cnt increments.
  - If c<OUT_W−1: c←c+1, s←0, go to ADV.
  - Otherwise go to NEXT_ROW.
- ADV (exactly STEP cycles): inc_en=1 in each cycle. Then go to REQ.
- NEXT_ROW (1 cycle): row_base←row_base+STEP·IMG_W, c←0.
  - If r<OUT_H−1: r←r+1, go to LOAD.
  - Otherwise go to FIN.
- FIN (1 cycle): done=1, busy=1. Then go to IDLE.
- Arithmetic: all address arithmetic is 32-bit modulo 2^32 (wraps silently). pix_cnt also wraps modulo 2^32.
- mem_ack outside REQ is ignored. rd_req is held until ack; it is never withdrawn, except by rst.
- Reset: from any state, on the next posedge go to IDLE and clear all outputs, pix_cnt and counters. An in-flight read is abandoned.

## Timing
- The register updates on negedge. A command issued in a posedge-to-posedge cycle takes effect mid-cycle. The register therefore holds the new address before the following posedge.
- Address presented in REQ = BASE + r·STEP·IMG_W + c·STEP.
- Latency from the start-sampling edge T0: LOAD occupies cycle 1.
- With zero-wait ack (mem_ack=1 throughout REQ), one row takes 1 + OUT_W + STEP·(OUT_W−1) + 1 cycles.
- done is high in the cycle following the last NEXT_ROW.
- Every wait cycle in REQ adds exactly one cycle to the total.
- pix_cnt equals OUT_W·OUT_H while done=1.

## Test plan
- IMG_W=8, IMG_H=4, STEP=2, BASE=0x100, mem_ack tied 1, start at T0:
  - read addresses in order: 0x100, 0x102, 0x104, 0x106, 0x110, 0x112, 0x114, 0x116;
  - done high in cycle 25 only; pix_cnt=8; busy low from cycle 26.
- Same config, mem_ack delayed 3 cycles on every read:
  - rd_req held steady, address stable throughout each REQ;
  - done in cycle 49; no inc_en or cbus_en asserted while rd_req=1.
- STEP=1, IMG_W=3, IMG_H=2, BASE=0xFFFFFFFE:
  - addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, then 0x1, 0x2, 0x3 (wrap-around);
  - pix_cnt=6.
- start pulsed again during REQ and during FIN:
  - ignored; the walk finishes normally; exactly one done pulse.
- rst asserted in ADV of row 1:
  - next posedge: IDLE, all outputs 0, pix_cnt=0.
  - A new start restarts from BASE with address 0x100.
- mem_ack pulsed while in LOAD/ADV: no effect on pix_cnt or state.
